ramfile_ctrl: RTL and testbench

//   Host-side controller for the KS10 1Kx36 RAMFILE (AC/workspace RAM).

---
 rtl/ramfile_ctrl_pkg.sv | 14 +
 rtl/ramfile_ctrl_if.sv | 17 +
 rtl/ramfile_ctrl.sv | 98 +++++++++
 tb/tb_ramfile_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ramfile_ctrl_pkg.sv
// Shared RAMFILE definitions: controller state encodings and default init constants.
package ramfile_ctrl_pkg;

   localparam logic [1:0] ST_INIT    = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_RD_WAIT = 2'd2;

   localparam int unsigned RF_ADDR_WIDTH   = 10;
   localparam int unsigned RF_DATA_WIDTH   = 36;
   localparam int unsigned RF_PRESET_ADDR  = 15;
   localparam logic [35:0] RF_INIT_VALUE   = 36'o000000_000000;
   localparam logic [35:0] RF_PRESET_VALUE = 36'o777577_030303;

endpackage

// File: rtl/ramfile_ctrl_if.sv
// Client request/response bus of the RAMFILE controller.
interface ramfile_ctrl_if
   import ramfile_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
);
   logic                  req;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (output req, req_wr, req_addr, req_data, input  ack, rsp_data);
   modport slave  (input  req, req_wr, req_addr, req_data, output ack, rsp_data);
endinterface

// File: rtl/ramfile_ctrl.sv
// KS10 RAMFILE host controller: power-up init sweep, then single-word req/ack
// reads and writes against an external registered-address RAM.
module ramfile_ctrl
   import ramfile_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = RF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH   = RF_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = RF_INIT_VALUE,
   parameter int                    PRESET_ADDR  = RF_PRESET_ADDR,
   parameter logic [DATA_WIDTH-1:0] PRESET_VALUE = RF_PRESET_VALUE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clken,
   ramfile_ctrl_if.slave         bus,
   output logic                  o_init_done,
   output logic                  o_ram_clken,
   output logic                  o_ram_wr,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_din,
   input  logic [DATA_WIDTH-1:0] i_ram_dout
);

   localparam logic [ADDR_WIDTH:0] LAST_CNT   = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] PRESET_CNT = PRESET_ADDR[ADDR_WIDTH:0];

   logic [1:0]            r_state;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic                  r_ack;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_init_done;
   logic                  w_accept;

   // The edge that raises ack must not take the same still-held request again.
   assign w_accept = bus.req & ~r_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_ack       <= 1'b0;
         r_rsp_data  <= '0;
         r_init_done <= 1'b0;
      end else begin
         // ack is a single clk pulse, independent of clken
         r_ack <= 1'b0;
         if (i_clken) begin
            case (r_state)
               ST_INIT: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT) begin
                     r_init_done <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
               ST_IDLE: begin
                  if (w_accept) begin
                     if (bus.req_wr) r_ack   <= 1'b1;
                     else            r_state <= ST_RD_WAIT;
                  end
               end
               ST_RD_WAIT: begin
                  r_rsp_data <= i_ram_dout;
                  r_ack      <= 1'b1;
                  r_state    <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      o_ram_clken = 1'b0;
      o_ram_wr    = 1'b0;
      o_ram_addr  = bus.req_addr;
      o_ram_din   = bus.req_data;
      case (r_state)
         ST_INIT: begin
            o_ram_clken = i_clken;
            o_ram_wr    = 1'b1;
            o_ram_addr  = r_cnt[ADDR_WIDTH-1:0];
            o_ram_din   = (r_cnt == PRESET_CNT) ? PRESET_VALUE : INIT_VALUE;
         end
         ST_IDLE: begin
            o_ram_clken = i_clken & w_accept;
            o_ram_wr    = w_accept & bus.req_wr;
         end
         // RD_WAIT keeps the RAM frozen so its latched read address is held
         default: ;
      endcase
   end

   assign bus.ack      = r_ack;
   assign bus.rsp_data = r_rsp_data;
   assign o_init_done  = r_init_done;

endmodule

// File: tb/tb_ramfile_ctrl.sv
// Directed bench for ramfile_ctrl with a behavioural 1Kx36 RAM and a read scoreboard.
module tb_ramfile_ctrl;
   import ramfile_ctrl_pkg::*;

   localparam logic [35:0] PRESET = 36'o777577_030303;

   logic        clk;
   logic        rst;
   logic        clken;
   logic        init_done, ram_clken, ram_wr;
   logic [9:0]  ram_addr;
   logic [35:0] ram_din, ram_dout;

   int checks   = 0;
   int failures = 0;
   int sweep_err = 0;

   logic [35:0] mem [0:1023];
   logic [9:0]  ram_areg;
   logic [10:0] sw_cnt;
   logic [35:0] sb_mem [0:1023];
   logic [35:0] sbq [$];

   ramfile_ctrl_if bif ();

   ramfile_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .i_clken     (clken),
      .bus         (bif),
      .o_init_done (init_done),
      .o_ram_clken (ram_clken),
      .o_ram_wr    (ram_wr),
      .o_ram_addr  (ram_addr),
      .o_ram_din   (ram_din),
      .i_ram_dout  (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM1Kx36 model: registered read address
   always @(posedge clk) begin
      if (ram_clken) begin
         if (ram_wr) mem[ram_addr] <= ram_din;
         ram_areg <= ram_addr;
      end
   end
   assign ram_dout = mem[ram_areg];

   // Sweep monitor: every pre-init write must follow 0,1,2.. with the init pattern
   always @(posedge clk or posedge rst) begin
      if (rst) sw_cnt <= '0;
      else if (ram_clken && ram_wr && !init_done) begin
         if (ram_addr !== sw_cnt[9:0] ||
             ram_din !== ((sw_cnt == 11'd15) ? PRESET : 36'd0))
            sweep_err <= sweep_err + 1;
         sw_cnt <= sw_cnt + 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_reset();
      for (int i = 0; i < 1024; i++) sb_mem[i] = 36'd0;
      sb_mem[15] = PRESET;
   endtask

   // Count clken edges from reset release until init_done is seen.
   task automatic wait_init(output int n);
      n = 0;
      for (int i = 0; i < 3000 && !init_done; i++) begin
         @(posedge clk); if (clken) n++;
         @(negedge clk);
      end
   endtask

   // One request; called and returns at a negedge. Reads are scored via sbq.
   task automatic op(input bit wr, input logic [9:0] a, input logic [35:0] d,
                     input bit toggle, output int n_edge, output int n_clk);
      bit got;
      logic [35:0] e;
      bif.req = 1'b1; bif.req_wr = wr; bif.req_addr = a; bif.req_data = d;
      clken = 1'b1;
      if (wr) sb_mem[a] = d; else sbq.push_back(sb_mem[a]);
      n_edge = 0; n_clk = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); n_clk++; if (clken) n_edge++;
         @(negedge clk);
         if (bif.ack) got = 1'b1;
         else if (toggle) clken = ~clken;
      end
      chk("ack_seen", 64'(got), 64'd1);
      if (got && !wr) begin
         e = (sbq.size() > 0) ? sbq.pop_front() : 36'hx;
         chk("rd_data", 64'(bif.rsp_data), 64'(e));
      end
      bif.req = 1'b0;
      if (toggle) clken = ~clken;
      @(posedge clk); @(negedge clk);
      chk("ack_width", 64'(bif.ack), 64'd0);
      clken = 1'b1;
   endtask

   int ne, nc, n;
   logic [63:0] rnd;
   logic [9:0]  ra;
   logic [35:0] rd;

   initial begin
      rst = 1'b1; clken = 1'b1;
      bif.req = 1'b0; bif.req_wr = 1'b0; bif.req_addr = '0; bif.req_data = '0;
      sb_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_ack",       64'(bif.ack),      64'd0);
      chk("rst_rsp",       64'(bif.rsp_data), 64'd0);
      chk("rst_init_done", 64'(init_done),    64'd0);
      chk("rst_ram_addr",  64'(ram_addr),     64'd0);
      chk("rst_ram_wr",    64'(ram_wr),       64'd1);

      rst = 1'b0;
      wait_init(n);
      chk("init_edges", 64'(n), 64'd1024);
      chk("sweep_ok", 64'(sweep_err), 64'd0);

      op(1'b0, 10'd15, '0, 1'b0, ne, nc);
      chk("rd_lat", 64'(ne), 64'd2);
      op(1'b0, 10'd0, '0, 1'b0, ne, nc);
      op(1'b0, 10'd1023, '0, 1'b0, ne, nc);

      op(1'b1, 10'd7, 36'o123456_654321, 1'b0, ne, nc);
      chk("wr_lat", 64'(ne), 64'd1);
      op(1'b0, 10'd7, '0, 1'b0, ne, nc);
      chk("raw_lat", 64'(ne), 64'd2);

      // clken toggling: two clken edges now span three clk cycles
      op(1'b0, 10'd15, '0, 1'b1, ne, nc);
      chk("tog_edges", 64'(ne), 64'd2);
      chk("tog_clks",  64'(nc), 64'd3);

      // reset during RD_WAIT drops the read
      bif.req = 1'b1; bif.req_wr = 1'b0; bif.req_addr = 10'd7;
      @(posedge clk); @(negedge clk);
      rst = 1'b1; #1;
      chk("rdw_rst_ack", 64'(bif.ack),      64'd0);
      chk("rdw_rst_rsp", 64'(bif.rsp_data), 64'd0);

      // mid-sweep reset at count 500
      bif.req = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (500) @(negedge clk);
      rst = 1'b1; #1;
      chk("mid_init_done", 64'(init_done), 64'd0);
      chk("mid_ram_addr",  64'(ram_addr),  64'd0);
      @(negedge clk); rst = 1'b0;
      sb_reset();
      wait_init(n);
      chk("reinit_edges", 64'(n), 64'd1024);
      chk("sweep_ok2", 64'(sweep_err), 64'd0);
      op(1'b0, 10'd7, '0, 1'b0, ne, nc);

      // request held through INIT: serviced only after init_done
      rst = 1'b1;
      bif.req = 1'b1; bif.req_wr = 1'b1; bif.req_addr = 10'd20; bif.req_data = 36'o555_444_333_222;
      @(negedge clk); rst = 1'b0;
      n = 0;
      for (int i = 0; i < 3000 && !init_done; i++) begin
         @(posedge clk); if (bif.ack) n = n + 1000;
         @(negedge clk); if (bif.ack) n++;
      end
      sb_reset();
      chk("init_no_ack", 64'(n), 64'd0);
      chk("sweep_ok3", 64'(sweep_err), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("post_init_ack", 64'(bif.ack), 64'd1);
      bif.req = 1'b0;
      sb_mem[20] = 36'o555_444_333_222;
      @(posedge clk); @(negedge clk);
      op(1'b0, 10'd20, '0, 1'b0, ne, nc);
      op(1'b0, 10'd15, '0, 1'b0, ne, nc);

      for (int k = 0; k < 100; k++) begin
         rnd = {$urandom, $urandom};
         ra  = rnd[45:36];
         rd  = rnd[35:0];
         op(1'b1, ra, rd, 1'b0, ne, nc);
         op(1'b0, ra, '0, 1'b0, ne, nc);
      end
      op(1'b0, 10'd20, '0, 1'b0, ne, nc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
